// File: rtl/keypad_emulator.sv
// Purpose : 4x4 matrix-keypad responder; answers the scanner's column drive on filas
//           like a physical key (press, hold, release, idle gap).
// Latency : filas follows columnas with one register stage; a request enters the
//           contact phase on the cycle after it is accepted.
// Backpressure: key_ready is low from acceptance until the gap has elapsed and
//           whenever enable is low; requests offered while key_ready is low are
//           dropped, not queued.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   enable       block enable; low aborts any key activity at the next edge
//   key_valid    request strobe
//   key_code     [3:2] row, [1:0] column of the key to press
//   hold_cycles  cycles the contact stays solidly closed (0 behaves as 1)
//   key_ready    request can be accepted this cycle
//   columnas     column drive from the scanner (active-high)
//   filas        registered row sense back to the scanner (active-high)
//   pressed      contact phase in progress (bounce or hold)
//   key_done     single-cycle pulse in the last gap cycle
//
// Optional feature: define KEYPAD_BOUNCE_EN to add press/release contact-bounce
// phases driven by an 8-bit LFSR (taps 8,6,5,4, seeded 8'hA5 at reset).

module keypad_emulator #(
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned BOUNCE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] hold_cycles,
    output logic        key_ready,
    input  logic [3:0]  columnas,
    output logic [3:0]  filas,
    output logic        pressed,
    output logic        key_done
);

    // Parameter sanity: both phases need at least one cycle.
    if (GAP_CYCLES < 1) begin : g_gap_chk
        $error("keypad_emulator: GAP_CYCLES must be >= 1");
    end
    if (BOUNCE_CYCLES < 1) begin : g_bounce_chk
        $error("keypad_emulator: BOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_PRESS_BOUNCE   = 3'd1,
        S_HOLD           = 3'd2,
        S_RELEASE_BOUNCE = 3'd3,
        S_GAP            = 3'd4
    } state_t;

    // Phase counters are loaded with (length - 1) and count down to zero,
    // so a 16-bit counter covers a 65535-cycle hold without wrapping.
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
    localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  key_q;
    logic        contact;
    logic        accept;
    logic [15:0] hold_last_in;
    logic [3:0]  filas_d;

`ifdef KEYPAD_BOUNCE_EN
    logic [7:0]  lfsr_q;
    logic [15:0] hold_last_q;
    logic        in_bounce;
`endif

    assign key_ready    = enable && (state_q == S_IDLE);
    assign accept       = key_valid && key_ready;
    assign hold_last_in = (hold_cycles == 16'd0) ? 16'd0 : hold_cycles - 16'd1;
    assign pressed      = (state_q == S_PRESS_BOUNCE) || (state_q == S_HOLD) ||
                          (state_q == S_RELEASE_BOUNCE);

    // Next-state, counter, contact and done-pulse decode. contact and key_done
    // are only raised on the enable-high path, so dropping enable opens the
    // contact and suppresses the done pulse in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        contact  = 1'b0;
        key_done = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_valid) begin
`ifdef KEYPAD_BOUNCE_EN
                        state_d = S_PRESS_BOUNCE;
                        cnt_d   = BOUNCE_LAST;
`else
                        state_d = S_HOLD;
                        cnt_d   = hold_last_in;
`endif
                    end
                end
`ifdef KEYPAD_BOUNCE_EN
                S_PRESS_BOUNCE: begin
                    contact = lfsr_q[0];
                    if (cnt_q == 16'd0) begin
                        state_d = S_HOLD;
                        cnt_d   = hold_last_q;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_RELEASE_BOUNCE: begin
                    contact = lfsr_q[0];
                    if (cnt_q == 16'd0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LAST;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
`endif
                S_HOLD: begin
                    contact = 1'b1;
                    if (cnt_q == 16'd0) begin
`ifdef KEYPAD_BOUNCE_EN
                        state_d = S_RELEASE_BOUNCE;
                        cnt_d   = BOUNCE_LAST;
`else
                        state_d = S_GAP;
                        cnt_d   = GAP_LAST;
`endif
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == 16'd0) begin
                        key_done = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Row sense: only the latched row can ever be driven, and only from the
    // latched column bit, so non-one-hot column patterns are harmless.
    always_comb begin
        filas_d = '0;
        for (int r = 0; r < 4; r++) begin
            filas_d[r] = (key_q[3:2] == 2'(r)) && contact && columnas[key_q[1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            filas   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            filas   <= filas_d;
            if (accept) begin
                key_q <= key_code;
            end
        end
    end

`ifdef KEYPAD_BOUNCE_EN
    assign in_bounce = (state_q == S_PRESS_BOUNCE) || (state_q == S_RELEASE_BOUNCE);

    // The LFSR only steps while bouncing, so the chatter pattern of each press
    // depends solely on how many bounce cycles have elapsed since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q      <= 8'hA5;
            hold_last_q <= '0;
        end else begin
            if (in_bounce) begin
                lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
            if (accept) begin
                hold_last_q <= hold_last_in;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

    localparam int GAP = 4;
    localparam int BNC = 8;
`ifdef KEYPAD_BOUNCE_EN
    localparam int B = BNC;
`else
    localparam int B = 0;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] hold_cycles;
    logic        key_ready;
    logic [3:0]  columnas;
    logic [3:0]  filas;
    logic        pressed;
    logic        key_done;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_lfsr   = 8'hA5;

    keypad_emulator #(.GAP_CYCLES(GAP), .BOUNCE_CYCLES(BNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .hold_cycles (hold_cycles),
        .key_ready   (key_ready),
        .columnas    (columnas),
        .filas       (filas),
        .pressed     (pressed),
        .key_done    (key_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference bounce source: Fibonacci LFSR, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // One complete key press, checked cycle by cycle against a phase schedule.
    // colmode: 0 random columnas, 1 rotating one-hot, 2 fixed colfix.
    // junk: offer key 4'hF requests while busy. abort_k: cycle with enable low (-1 none).
    task automatic run_press(input logic [3:0] code, input logic [15:0] hold,
                             input int colmode, input logic [3:0] colfix,
                             input bit junk, input int abort_k, input string tag);
        int         h, total, row, col;
        bit         prev_c, c, in_b, in_h;
        logic [3:0] prev_col, cval, exp_f;
        bit         exp_p, exp_d, exp_r;
        h     = (hold == 16'd0) ? 1 : int'(hold);
        total = 2 * B + h + GAP;
        row   = int'(code[3:2]);
        col   = int'(code[1:0]);

        @(posedge clk); #1;
        key_valid   = 1'b1;
        key_code    = code;
        hold_cycles = hold;
        columnas    = 4'($urandom);
        @(negedge clk);
        n_checks++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept key_ready got %b want 1", tag, key_ready);
        end
        prev_c   = 1'b0;
        prev_col = columnas;
        @(posedge clk); #1;

        for (int k = 0; k <= total; k++) begin
            case (colmode)
                1:       cval = 4'b0001 << (k % 4);
                2:       cval = colfix;
                default: cval = 4'($urandom);
            endcase
            columnas = cval;
            if (junk && k < total) begin
                key_valid   = 1'($urandom);
                key_code    = 4'hF;
                hold_cycles = 16'($urandom);
            end else begin
                key_valid = 1'b0;
            end
            if (k == abort_k) enable = 1'b0;
            @(negedge clk);

            in_b  = (k < B) || (k >= B + h && k < 2 * B + h);
            in_h  = (k >= B) && (k < B + h);
            exp_f = (prev_c && prev_col[col]) ? (4'b0001 << row) : 4'b0000;
            exp_p = (k < 2 * B + h);
            exp_d = (k == total - 1) && (k != abort_k);
            exp_r = (k == total);

            n_checks++;
            if (filas !== exp_f) begin
                n_fail++;
                $display("FAIL %s filas k=%0d got %b want %b", tag, k, filas, exp_f);
            end
            n_checks++;
            if (pressed !== exp_p) begin
                n_fail++;
                $display("FAIL %s pressed k=%0d got %b want %b", tag, k, pressed, exp_p);
            end
            n_checks++;
            if (key_done !== exp_d) begin
                n_fail++;
                $display("FAIL %s key_done k=%0d got %b want %b", tag, k, key_done, exp_d);
            end
            n_checks++;
            if (key_ready !== exp_r) begin
                n_fail++;
                $display("FAIL %s key_ready k=%0d got %b want %b", tag, k, key_ready, exp_r);
            end

            if (in_b) begin
                c      = m_lfsr[0];
                m_lfsr = lfsr_step(m_lfsr);
            end else begin
                c = in_h;
            end
            if (k == abort_k) c = 1'b0;
            prev_c   = c;
            prev_col = cval;
            @(posedge clk); #1;
            if (k == abort_k) break;
        end

        if (abort_k >= 0) begin
            for (int j = 0; j < 3; j++) begin
                columnas = 4'b1111;
                @(negedge clk);
                n_checks++;
                if ({filas, pressed, key_done, key_ready} !== 7'b0) begin
                    n_fail++;
                    $display("FAIL %s disabled j=%0d got filas=%b p=%b d=%b r=%b want all 0",
                             tag, j, filas, pressed, key_done, key_ready);
                end
                @(posedge clk); #1;
            end
            enable = 1'b1;
            @(negedge clk);
            n_checks++;
            if (key_ready !== 1'b1 || key_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s reenable got ready=%b done=%b want 1/0", tag, key_ready, key_done);
            end
        end
    endtask

    task automatic test_reset();
        enable      = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        hold_cycles = 16'd0;
        columnas    = 4'b0001;
        reset       = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({filas, pressed, key_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_in got filas=%b p=%b d=%b want 0", filas, pressed, key_done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        m_lfsr = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({filas, pressed, key_done, key_ready} !== 7'b0000_001) begin
            n_fail++;
            $display("FAIL reset_out got filas=%b p=%b d=%b r=%b want 0000/0/0/1",
                     filas, pressed, key_done, key_ready);
        end
    endtask

    task automatic test_onehot_scan();
        run_press(4'h6, 16'd5, 1, 4'b0000, 1'b0, -1, "onehot_scan");
    endtask

    task automatic test_busy_ignored();
        run_press(4'h6, 16'd5, 0, 4'b0000, 1'b1, -1, "busy_ignored");
    endtask

    task automatic test_hold_zero();
        run_press(4'h0, 16'd0, 2, 4'b0001, 1'b0, -1, "hold_zero");
    endtask

    task automatic test_enable_abort();
        run_press(4'hA, 16'd10, 1, 4'b0000, 1'b0, B + 2, "enable_abort");
    endtask

    task automatic test_bounce();
        run_press(4'h5, 16'd4, 2, 4'b0010, 1'b0, -1, "bounce");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_press(4'($urandom), 16'($urandom_range(0, 12)), 0, 4'b0000, 1'b1, -1,
                      "back_to_back");
        end
    endtask

    task automatic test_reset_mid_press();
        @(posedge clk); #1;
        key_valid   = 1'b1;
        key_code    = 4'h0;
        hold_cycles = 16'd20;
        columnas    = 4'b0001;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (B + 3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (filas !== 4'b0001 || pressed !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_press_hold got filas=%b p=%b want 0001/1", filas, pressed);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({filas, pressed, key_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_press_reset got filas=%b p=%b d=%b want 0", filas, pressed, key_done);
        end
        #2 reset = 1'b1;
        m_lfsr = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (key_ready !== 1'b1 || filas !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_press_after got r=%b filas=%b want 1/0000", key_ready, filas);
        end
    endtask

    task automatic test_long_hold();
        run_press(4'h9, 16'hFFFF, 2, 4'b0110, 1'b0, -1, "long_hold");
    endtask

    initial begin
        test_reset();
        test_onehot_scan();
        test_busy_ignored();
        test_hold_zero();
        test_enable_abort();
        test_bounce();
        test_back_to_back();
        test_reset_mid_press();
        test_bounce();
        test_long_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable 4x4 matrix-keypad responder for the calculator: the far end of the row/column scan interface driven by the keypad scanner in topLevel.
- Accepts "press key N for T cycles" requests from a bench or sequencer.
- Drives filas in response to the scanner's columnas, exactly as a physical keypad would: press, hold, release, then a mandatory idle gap.

Parameters:
- GAP_CYCLES, 4: idle cycles enforced after release before the next request is accepted (min 1).
- BOUNCE_CYCLES, 8: length of each contact-bounce phase; used only when KEYPAD_BOUNCE_EN is defined (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; low aborts any key activity.
- key_valid  input  1  request strobe.
- key_code  input  4  key to press; [3:2] = row, [1:0] = column.
- hold_cycles  input  16  cycles the key stays solidly closed; 0 is treated as 1.
- key_ready  output  1  high when a request can be accepted.
- columnas  input  4  column drive from the scanner, active-high, normally one-hot.
- filas  output  4  row sense back to the scanner, active-high, registered.
- pressed  output  1  high while the contact is closed (bounce or hold phases).
- key_done  output  1  one-cycle pulse at the end of the gap.

Behaviour:
- Reset (reset=0, asynchronous), all outputs low, state IDLE, counters 0, LFSR = 8'hA5.
- Handshake:
  - key_ready = enable and state==IDLE.
  - A request is accepted on a rising edge with key_valid & key_ready; key_code and hold_cycles are latched at that edge.
  - key_valid without key_ready is ignored; requests are not queued.
- States: IDLE -> PRESS_BOUNCE -> HOLD -> RELEASE_BOUNCE -> GAP -> IDLE.
- Without KEYPAD_BOUNCE_EN, both bounce states are skipped: IDLE -> HOLD and HOLD -> GAP.
- HOLD:
  - Lasts exactly max(hold_cycles,1) cycles.
  - Contact closed, so filas[row] is registered from columnas[col] each cycle.
- GAP:
  - Lasts GAP_CYCLES cycles, with contact open.
  - key_done pulses in the last GAP cycle; IDLE (key_ready=1) follows on the next cycle.
- Row drive:
  - filas is a register updated every cycle: filas[r] <= (r==row) & contact & columnas[col].
  - This gives 1 cycle of latency from a columnas change to filas.
  - Non-one-hot columnas is legal; only the latched column bit matters.
  - columnas=0 yields filas=0.
  - The other three filas bits are always 0.
- pressed is high from the first PRESS_BOUNCE/HOLD cycle through the last RELEASE_BOUNCE/HOLD cycle.
- enable low:
  - In any state, enable low forces IDLE at the next edge.
  - filas=0 and pressed=0 from that edge.
  - No key_done pulse; latched request discarded.
  - key_ready stays low while enable is low.
- Counters are 16 bits; hold_cycles=16'hFFFF is held for 65535 cycles without wrap.
- Reset mid-press clears immediately; filas drops asynchronously.

Optional Feature:
- Macro: KEYPAD_BOUNCE_EN.
- Defined:
  - PRESS_BOUNCE and RELEASE_BOUNCE each last BOUNCE_CYCLES cycles.
  - During these phases contact = lfsr[0], from an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded 8'hA5 at reset.
  - The LFSR advances every cycle in a bounce state and holds otherwise.
  - filas therefore chatters while the scanned column is active.
- Not defined:
  - No LFSR and no bounce states.
  - Contact is a clean step at the HOLD boundaries.

Test Plan:
- Reset then release, columnas=4'b0001 → filas=0, key_ready=1, pressed=0, key_done=0.
- Without bounce: accept key_code=4'h6 with hold_cycles=5 and columnas cycling one-hot every cycle → filas=4'b0010 one cycle after each columnas=4'b0100, else 0. Sequence: 5 HOLD cycles, then 4 GAP cycles, key_done pulse, key_ready back high.
- key_valid asserted while busy with key_code=4'hF → ignored; filas never shows bit 3, no extra key_done.
- hold_cycles=0, key_code=4'h0, columnas=4'b0001 held → filas=4'b0001 for exactly 1 cycle.
- enable dropped on the 3rd HOLD cycle (key 4'hA, hold 10) → filas=0 next cycle, no key_done; after enable=1 → key_ready=1.
- With KEYPAD_BOUNCE_EN, key 4'h5, hold 4, columnas=4'b0010 fixed → filas[1] follows lfsr[0] for 8 cycles, is solid 1 for 4 cycles, chatters for 8 cycles, then is 0 through the gap. The chatter pattern must be deterministic across runs.
